// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding,
// default parameter values and the saturation limit of the measurement counters.
`timescale 1ns/1ps
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    localparam int unsigned WIDTH_DEFAULT    = 8;
    localparam int unsigned SYNC_DEP_DEFAULT = 2;

    // Largest value of a WIDTH+1 bit measurement counter.
    function automatic logic [31:0] cnt_max(input int unsigned width);
        cnt_max = (32'd1 << (width + 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM pin into the clk domain and derives single-cycle
// rise/fall pulses from the synchronized level.
`timescale 1ns/1ps
module pwm_sync_edge
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_DEP = SYNC_DEP_DEFAULT  // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic s_in,
    output logic rise,
    output logic fall,
    output logic primed
);

    logic [SYNC_DEP-1:0] sync_r;
    logic [SYNC_DEP-1:0] primed_r;
    logic                s_prev_r;

    // Synchronizer chain, previous-level register and pipeline-fill tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r   <= {SYNC_DEP{1'b0}};
            primed_r <= {SYNC_DEP{1'b0}};
            s_prev_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_DEP-2:0], pwm_in};
            primed_r <= {primed_r[SYNC_DEP-2:0], 1'b1};
            s_prev_r <= sync_r[SYNC_DEP-1];
        end
    end

    // primed goes high once the chain holds real pin samples rather than the
    // cleared reset value, so a pin high at reset release is not mistaken for a low.
    assign s_in   = sync_r[SYNC_DEP-1];
    assign rise   = sync_r[SYNC_DEP-1] & ~s_prev_r;
    assign fall   = ~sync_r[SYNC_DEP-1] & s_prev_r;
    assign primed = primed_r[SYNC_DEP-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input in clk cycles, strobes each
// completed measurement and flags a pin stuck high or low.
`timescale 1ns/1ps
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned SYNC_DEP = SYNC_DEP_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pwm_in,
    output logic [WIDTH:0] period_meas,
    output logic [WIDTH:0] duty_meas,
    output logic           meas_valid,
    output logic           stuck_hi,
    output logic           stuck_lo
);

    localparam int unsigned    CW      = WIDTH + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(cnt_max(WIDTH));
    localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic          s_in_s;
    logic          rise_s;
    logic          fall_s;
    logic          primed_s;
    logic          cnt_sat_s;

    pwm_state_e    state_r;
    pwm_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] hi_lat_r;
    logic [CW-1:0] hi_lat_nxt_s;
    logic          seen_low_r;
    logic          seen_low_nxt_s;
    logic [CW-1:0] period_nxt_s;
    logic [CW-1:0] duty_nxt_s;
    logic          valid_nxt_s;
    logic          stuck_hi_nxt_s;
    logic          stuck_lo_nxt_s;

    pwm_sync_edge #(
        .SYNC_DEP (SYNC_DEP)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .s_in   (s_in_s),
        .rise   (rise_s),
        .fall   (fall_s),
        .primed (primed_s)
    );

    assign cnt_sat_s = (cnt_r == CNT_MAX);

    // Cycle counter: reloads on every rise so its value at a rise is the full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (!cnt_sat_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state and next-output logic; an edge always takes priority over a timeout.
    always_comb begin
        state_nxt_s    = state_r;
        seen_low_nxt_s = seen_low_r;
        hi_lat_nxt_s   = hi_lat_r;
        period_nxt_s   = period_meas;
        duty_nxt_s     = duty_meas;
        valid_nxt_s    = 1'b0;
        stuck_hi_nxt_s = stuck_hi;
        stuck_lo_nxt_s = stuck_lo;

        case (state_r)
            IDLE: begin
                if (rise_s && seen_low_r) begin
                    state_nxt_s = HIGH;
                end else if (primed_s && !s_in_s) begin
                    seen_low_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    hi_lat_nxt_s = cnt_r;
                    state_nxt_s  = LOW;
                end else if (cnt_sat_s) begin
                    stuck_hi_nxt_s = 1'b1;
                    stuck_lo_nxt_s = 1'b0;
                    seen_low_nxt_s = 1'b0;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            LOW: begin
                if (rise_s) begin
                    period_nxt_s   = cnt_r;
                    duty_nxt_s     = hi_lat_r;
                    valid_nxt_s    = 1'b1;
                    stuck_hi_nxt_s = 1'b0;
                    stuck_lo_nxt_s = 1'b0;
                    state_nxt_s    = HIGH;
                end else if (cnt_sat_s) begin
                    stuck_lo_nxt_s = 1'b1;
                    stuck_hi_nxt_s = 1'b0;
                    seen_low_nxt_s = 1'b0;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s = LOW;
                end
            end
            default: begin
                seen_low_nxt_s = 1'b0;
                state_nxt_s    = IDLE;
            end
        endcase
    end

    // State, latched high time and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            seen_low_r  <= 1'b0;
            hi_lat_r    <= {CW{1'b0}};
            period_meas <= {CW{1'b0}};
            duty_meas   <= {CW{1'b0}};
            meas_valid  <= 1'b0;
            stuck_hi    <= 1'b0;
            stuck_lo    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            seen_low_r  <= seen_low_nxt_s;
            hi_lat_r    <= hi_lat_nxt_s;
            period_meas <= period_nxt_s;
            duty_meas   <= duty_nxt_s;
            meas_valid  <= valid_nxt_s;
            stuck_hi    <= stuck_hi_nxt_s;
            stuck_lo    <= stuck_lo_nxt_s;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture (WIDTH=8, SYNC_DEP=2): a strobe monitor
// queues every measurement and each scenario task checks what it expects.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_in;
    logic [8:0] period_meas;
    logic [8:0] duty_meas;
    logic       meas_valid;
    logic       stuck_hi;
    logic       stuck_lo;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] per_q[$];
    logic [8:0] duty_q[$];
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    pwm_capture #(
        .WIDTH    (8),
        .SYNC_DEP (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .period_meas (period_meas),
        .duty_meas   (duty_meas),
        .meas_valid  (meas_valid),
        .stuck_hi    (stuck_hi),
        .stuck_lo    (stuck_lo)
    );

    // Strobe monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            per_q.push_back(period_meas);
            duty_q.push_back(duty_meas);
            checks++;
            if (prev_valid !== 1'b0) begin
                errors++;
                $display("FAIL strobe_width: meas_valid=%b for two cycles, required 0 on the second", meas_valid);
            end
        end
        prev_valid = meas_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        per_q.delete();
        duty_q.delete();
    endtask

    // One synchronous pin period starting with a rising edge.
    task automatic drive_period(input int per, input int hi);
        pwm_in = 1'b1;
        cycles(hi);
        pwm_in = 1'b0;
        cycles(per - hi);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        cycles(4);
        checks++; if (period_meas !== 9'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period_meas); end
        checks++; if (duty_meas !== 9'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_meas); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL reset_stuck_hi: got %b want 0", stuck_hi); end
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL reset_stuck_lo: got %b want 0", stuck_lo); end
        rst = 1'b0;
        cycles(3);
    endtask

    task automatic test_basic();
        clear_q();
        repeat (5) drive_period(128, 32);
        // First rise only arms, the remaining four each close a period.
        checks++; if (per_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d strobes want 4", per_q.size()); end
        foreach (per_q[i]) begin
            checks++; if (per_q[i] !== 9'd128) begin errors++; $display("FAIL basic_period[%0d]: got %0d want 128", i, per_q[i]); end
            checks++; if (duty_q[i] !== 9'd32) begin errors++; $display("FAIL basic_duty[%0d]: got %0d want 32", i, duty_q[i]); end
        end
        checks++; if ({stuck_hi, stuck_lo} !== 2'b00) begin errors++; $display("FAIL basic_stuck: got %b%b want 00", stuck_hi, stuck_lo); end
    endtask

    task automatic test_duty_change();
        clear_q();
        repeat (2) drive_period(128, 96);
        checks++; if (per_q.size() !== 2) begin errors++; $display("FAIL dchg_count: got %0d strobes want 2", per_q.size()); end
        if (per_q.size() == 2) begin
            checks++; if (per_q[0] !== 9'd128 || duty_q[0] !== 9'd32) begin errors++; $display("FAIL dchg_first: got %0d/%0d want 128/32", per_q[0], duty_q[0]); end
            checks++; if (per_q[1] !== 9'd128 || duty_q[1] !== 9'd96) begin errors++; $display("FAIL dchg_second: got %0d/%0d want 128/96", per_q[1], duty_q[1]); end
        end
    endtask

    task automatic test_jitter();
        clear_q();
        #2;
        for (int k = 0; k < 4; k++) begin
            pwm_in = 1'b1;
            #480;
            pwm_in = 1'b0;
            #160;
        end
        @(posedge clk);
        #1;
        checks++; if (per_q.size() !== 4) begin errors++; $display("FAIL jit_count: got %0d strobes want 4", per_q.size()); end
        if (per_q.size() == 4) begin
            checks++;
            if (per_q[0] < 9'd127 || per_q[0] > 9'd129 || duty_q[0] < 9'd95 || duty_q[0] > 9'd97) begin
                errors++; $display("FAIL jit_first: got %0d/%0d want 128/96 +/-1", per_q[0], duty_q[0]);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (per_q[i] < 9'd63 || per_q[i] > 9'd65 || duty_q[i] < 9'd47 || duty_q[i] > 9'd49) begin
                    errors++; $display("FAIL jit_meas[%0d]: got %0d/%0d want 64/48 +/-1", i, per_q[i], duty_q[i]);
                end
            end
        end
    endtask

    task automatic test_stuck_lo();
        clear_q();
        // Realigning to the clock after the offset traffic stretches that last low phase by one cycle.
        drive_period(64, 48);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL slo_pre_count: got %0d strobes want 1", per_q.size()); end
        if (per_q.size() == 1) begin
            checks++; if (per_q[0] !== 9'd65 || duty_q[0] !== 9'd48) begin errors++; $display("FAIL slo_pre_meas: got %0d/%0d want 65/48", per_q[0], duty_q[0]); end
        end
        // cnt reaches 511 after edge 513 of this period, the flag registers on edge 514.
        cycles(449);
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL slo_early: got %b want 0 at edge 513", stuck_lo); end
        cycles(1);
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL slo_set: got %b want 1 at edge 514", stuck_lo); end
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL slo_hi_clear: got %b want 0", stuck_hi); end
        cycles(86);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL slo_no_strobe: got %0d strobes want 1", per_q.size()); end
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL slo_sticky: got %b want 1", stuck_lo); end
        clear_q();
        drive_period(128, 32);
        checks++; if (per_q.size() !== 0) begin errors++; $display("FAIL slo_arm: got %0d strobes want 0", per_q.size()); end
        checks++; if (stuck_lo !== 1'b1) begin errors++; $display("FAIL slo_arm_flag: got %b want 1", stuck_lo); end
        drive_period(128, 32);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL slo_resume_count: got %0d strobes want 1", per_q.size()); end
        if (per_q.size() == 1) begin
            checks++; if (per_q[0] !== 9'd128 || duty_q[0] !== 9'd32) begin errors++; $display("FAIL slo_resume_meas: got %0d/%0d want 128/32", per_q[0], duty_q[0]); end
        end
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL slo_cleared: got %b want 0", stuck_lo); end
    endtask

    task automatic test_stuck_hi();
        clear_q();
        pwm_in = 1'b1;
        cycles(513);
        checks++; if (stuck_hi !== 1'b0) begin errors++; $display("FAIL shi_early: got %b want 0 at edge 513", stuck_hi); end
        cycles(1);
        checks++; if (stuck_hi !== 1'b1) begin errors++; $display("FAIL shi_set: got %b want 1 at edge 514", stuck_hi); end
        checks++; if (stuck_lo !== 1'b0) begin errors++; $display("FAIL shi_lo_clear: got %b want 0", stuck_lo); end
        cycles(86);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL shi_count: got %0d strobes want 1", per_q.size()); end
        if (per_q.size() == 1) begin
            checks++; if (per_q[0] !== 9'd128 || duty_q[0] !== 9'd32) begin errors++; $display("FAIL shi_close_meas: got %0d/%0d want 128/32", per_q[0], duty_q[0]); end
        end
        // Back in IDLE: the next rise must only arm.
        pwm_in = 1'b0;
        cycles(10);
        clear_q();
        drive_period(128, 32);
        checks++; if (per_q.size() !== 0) begin errors++; $display("FAIL shi_idle: got %0d strobes want 0", per_q.size()); end
        checks++; if (stuck_hi !== 1'b1) begin errors++; $display("FAIL shi_sticky: got %b want 1", stuck_hi); end
    endtask

    task automatic test_reset_mid_low();
        clear_q();
        drive_period(128, 32);
        checks++; if (per_q.size() !== 1 || stuck_hi !== 1'b0) begin errors++; $display("FAIL rml_pre: got %0d strobes stuck_hi=%b want 1 strobe stuck_hi=0", per_q.size(), stuck_hi); end
        pwm_in = 1'b1;
        cycles(32);
        pwm_in = 1'b0;
        cycles(30);
        rst = 1'b1;
        cycles(1);
        checks++;
        if (period_meas !== 9'd0 || duty_meas !== 9'd0 || meas_valid !== 1'b0 || stuck_hi !== 1'b0 || stuck_lo !== 1'b0) begin
            errors++; $display("FAIL rml_outputs: got %0d/%0d v=%b hi=%b lo=%b want all 0", period_meas, duty_meas, meas_valid, stuck_hi, stuck_lo);
        end
        rst = 1'b0;
        cycles(40);
        clear_q();
        drive_period(128, 32);
        checks++; if (per_q.size() !== 0) begin errors++; $display("FAIL rml_arm: got %0d strobes want 0", per_q.size()); end
        drive_period(128, 32);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL rml_count: got %0d strobes want 1", per_q.size()); end
        if (per_q.size() == 1) begin
            checks++; if (per_q[0] !== 9'd128 || duty_q[0] !== 9'd32) begin errors++; $display("FAIL rml_meas: got %0d/%0d want 128/32", per_q[0], duty_q[0]); end
        end
    endtask

    task automatic test_release_high();
        rst = 1'b1;
        pwm_in = 1'b1;
        cycles(4);
        rst = 1'b0;
        clear_q();
        cycles(30);
        pwm_in = 1'b0;
        cycles(20);
        drive_period(100, 40);
        checks++; if (per_q.size() !== 0) begin errors++; $display("FAIL rel_no_arm: got %0d strobes want 0", per_q.size()); end
        drive_period(100, 40);
        checks++; if (per_q.size() !== 1) begin errors++; $display("FAIL rel_count: got %0d strobes want 1", per_q.size()); end
        if (per_q.size() == 1) begin
            checks++; if (per_q[0] !== 9'd100 || duty_q[0] !== 9'd40) begin errors++; $display("FAIL rel_meas: got %0d/%0d want 100/40", per_q[0], duty_q[0]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_duty_change();
        test_jitter();
        test_stuck_lo();
        test_stuck_hi();
        test_reset_mid_low();
        test_release_high();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
